// File: rtl/sha3_absorb_padder.sv
// SHA3-256 absorb-side padder: packs 64-bit little-endian message words into
// 17-lane rate blocks, applies pad10*1 with domain suffix 0x06, and hands each block downstream.
module sha3_absorb_padder #(
  localparam int RATE_LANES = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [63:0]                 in_data,
  input  logic [3:0]                  in_bytes,
  input  logic                        in_last,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [RATE_LANES-1:0][63:0] blk_data,
  output logic                        blk_last
);

  localparam int RATE_BYTES = RATE_LANES * 8;
  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);
  localparam logic [RATE_LANES-1:0][63:0] PAD_ONLY =
    {8'h80, {(RATE_BYTES * 8 - 16){1'b0}}, 8'h06};

  typedef enum logic {FILL, OUT} state_t;

  state_t                        state_reg, state_next;
  logic [4:0]                    lane_reg, lane_next;
  logic                          need_pad_reg, need_pad_next;
  logic                          blk_last_reg, blk_last_next;
  logic [RATE_LANES-1:0][63:0]   buffer_reg, buffer_next;

  logic [3:0]                    eff_bytes;
  logic [7:0]                    pad_pos;
  logic [63:0]                   word_masked;
  logic [RATE_BYTES*8-1:0]       pad_vec;

  // Byte count only matters on the last word; out-of-range counts saturate at a full word.
  assign eff_bytes = !in_last ? 4'd8 : ((in_bytes > 4'd8) ? 4'd8 : in_bytes);
  assign pad_pos   = {lane_reg, 3'b000} + {4'b0000, eff_bytes};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign word_masked[8*gi +: 8] = (4'(gi) < eff_bytes) ? in_data[8*gi +: 8] : 8'h00;
    end
    // Suffix byte lands at pad_pos; the closing 0x80 always sits in the top byte of the rate.
    for (genvar gi = 0; gi < RATE_BYTES; gi++) begin : g_pad
      assign pad_vec[8*gi +: 8] = ((pad_pos == 8'(gi)) ? 8'h06 : 8'h00) |
                                  ((gi == RATE_BYTES - 1) ? 8'h80 : 8'h00);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FILL;
      lane_reg     <= '0;
      need_pad_reg <= 1'b0;
      blk_last_reg <= 1'b0;
      buffer_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      lane_reg     <= lane_next;
      need_pad_reg <= need_pad_next;
      blk_last_reg <= blk_last_next;
      buffer_reg   <= buffer_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lane_next     = lane_reg;
    need_pad_next = need_pad_reg;
    blk_last_next = blk_last_reg;
    buffer_next   = buffer_reg;
    case (state_reg)
      FILL: begin
        if (in_valid) begin
          buffer_next[lane_reg] = word_masked;
          if (!in_last) begin
            if (lane_reg == LAST_LANE) begin
              state_next    = OUT;
              blk_last_next = 1'b0;
            end else begin
              lane_next = lane_reg + 5'd1;
            end
          end else if (lane_reg == LAST_LANE && eff_bytes == 4'd8) begin
            // Message exactly fills the rate: padding needs a block of its own.
            state_next    = OUT;
            blk_last_next = 1'b0;
            need_pad_next = 1'b1;
          end else begin
            buffer_next   = buffer_next | pad_vec;
            state_next    = OUT;
            blk_last_next = 1'b1;
          end
        end
      end
      OUT: begin
        if (blk_ready) begin
          lane_next = '0;
          if (need_pad_reg) begin
            buffer_next   = PAD_ONLY;
            blk_last_next = 1'b1;
            need_pad_next = 1'b0;
          end else begin
            buffer_next   = '0;
            state_next    = FILL;
            blk_last_next = 1'b0;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign in_ready  = (state_reg == FILL) && !rst;
  assign blk_valid = (state_reg == OUT);
  assign blk_data  = buffer_reg;
  assign blk_last  = blk_last_reg;

endmodule

// File: tb/tb_sha3_absorb_padder.sv
// Randomized bench for sha3_absorb_padder: a byte-level pad10*1 model produces
// expected rate blocks and handshake timing for each generated message.
module tb_sha3_absorb_padder;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic [3:0]        in_bytes;
  logic              in_last;
  logic              blk_valid;
  logic              blk_ready;
  logic [16:0][63:0] blk_data;
  logic              blk_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] msg_q[$];

  sha3_absorb_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive msg_q as one message and check every block and every handshake cycle.
  task automatic run_msg(input string name, input bit empty_tail, input int vld_pct,
                         input int rdy_pct, input int hold);
    logic [7:0]  pb[$];
    logic [63:0] wd[$];
    logic [3:0]  wb[$];
    bit          wl[$];
    int len, nb, nw, wi, bi, cyc, acc, pend_cnt;
    bit pending, acc_now, hs_now;
    len = msg_q.size();
    pb = msg_q;
    pb.push_back(8'h06);
    while (pb.size() % 136 != 0) pb.push_back(8'h00);
    pb[pb.size()-1] = pb[pb.size()-1] | 8'h80;
    nb = pb.size() / 136;

    for (int k = 0; (k * 8 < len) || (k == 0); k++) begin
      logic [63:0] w;
      int nbytes;
      w = {$urandom, $urandom};
      nbytes = len - 8 * k;
      if (nbytes > 8) nbytes = 8;
      for (int j = 0; j < 8; j++)
        if (j < nbytes) w[8*j +: 8] = msg_q[8*k + j];
      wd.push_back(w);
      wb.push_back(4'(nbytes));
      wl.push_back(1'b0);
    end
    if (empty_tail && len > 0 && len % 8 == 0) begin
      wd.push_back({$urandom, $urandom});
      wb.push_back(4'd0);
      wl.push_back(1'b0);
    end
    nw = wd.size();
    wl[nw-1] = 1'b1;
    for (int k = 0; k < nw - 1; k++) wb[k] = 4'($urandom);

    wi = 0; bi = 0; cyc = 0; acc = 0; pend_cnt = 0; pending = 1'b0;
    while ((wi < nw || bi < nb) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      check({name, "/blk_valid"}, 64'(blk_valid), 64'(pending));
      check({name, "/in_ready"}, 64'(in_ready), 64'(!pending));
      if (blk_valid && bi < nb) begin
        for (int l = 0; l < 17; l++) begin
          logic [63:0] e;
          for (int j = 0; j < 8; j++) e[8*j +: 8] = pb[bi*136 + l*8 + j];
          check($sformatf("%s/b%0d/lane%0d", name, bi, l), blk_data[l], e);
        end
        check($sformatf("%s/b%0d/last", name, bi), 64'(blk_last), 64'(bi == nb - 1));
      end else if (blk_valid) begin
        check({name, "/extra_blk"}, 64'(blk_valid), 64'(0));
      end

      in_valid = (wi < nw) && ($urandom_range(99) < vld_pct);
      if (in_valid) begin
        in_data = wd[wi]; in_bytes = wb[wi]; in_last = wl[wi];
      end else begin
        in_data = {$urandom, $urandom}; in_bytes = 4'($urandom); in_last = 1'($urandom);
      end
      if (hold > 0) blk_ready = (pend_cnt >= hold);
      else          blk_ready = ($urandom_range(99) < rdy_pct);

      acc_now = in_valid && !pending;
      hs_now  = pending && blk_ready;
      if (pending) pend_cnt++;
      if (acc_now) begin
        wi++;
        acc++;
        if (wl[wi-1] || acc == 17) begin
          pending = 1'b1;
          acc = 0;
        end
      end
      if (hs_now) begin
        $display("%s: block %0d of %0d handed off, last=%0d", name, bi, nb, blk_last);
        pend_cnt = 0;
        if (!(bi < nb - 1 && wi == nw)) pending = 1'b0;
        bi++;
      end
    end
    check({name, "/timeout"}, 64'(wi < nw || bi < nb), 64'(0));
    @(negedge clk);
    check({name, "/idle_valid"}, 64'(blk_valid), 64'(0));
    check({name, "/idle_ready"}, 64'(in_ready), 64'(1));
    in_valid  = 1'b0;
    blk_ready = 1'b0;
  endtask

  task automatic rand_msg(input int len);
    msg_q = {};
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0; blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/in_ready", 64'(in_ready), 64'(0));
    check("rst/blk_valid", 64'(blk_valid), 64'(0));
    check("rst/blk_last", 64'(blk_last), 64'(0));
    for (int l = 0; l < 17; l++) check($sformatf("rst/lane%0d", l), blk_data[l], 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rel/in_ready", 64'(in_ready), 64'(1));

    msg_q = {};
    run_msg("empty", 1'b0, 100, 100, 0);
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg("abc", 1'b0, 100, 100, 0);
    rand_msg(135);
    run_msg("len135", 1'b0, 100, 100, 0);
    rand_msg(136);
    run_msg("len136", 1'b0, 100, 100, 0);
    rand_msg(136);
    run_msg("len136_tail", 1'b1, 80, 100, 0);
    rand_msg(20);
    run_msg("backpressure", 1'b0, 100, 0, 10);

    // Reset after nine accepted words must discard the partial block.
    for (int k = 0; k < 9; k++) begin
      check($sformatf("part/in_ready%0d", k), 64'(in_ready), 64'(1));
      in_valid = 1'b1; in_data = {$urandom, $urandom}; in_bytes = 4'd8; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst/in_ready", 64'(in_ready), 64'(0));
    check("midrst/blk_valid", 64'(blk_valid), 64'(0));
    for (int l = 0; l < 17; l++) check($sformatf("midrst/lane%0d", l), blk_data[l], 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("midrst/rel_ready", 64'(in_ready), 64'(1));
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg("abc_after_rst", 1'b0, 100, 100, 0);

    for (int t = 0; t < 30; t++) begin
      int len;
      case ($urandom_range(3))
        0:       len = $urandom_range(0, 40);
        1:       len = $urandom_range(126, 146);
        2:       len = $urandom_range(262, 282);
        default: len = $urandom_range(0, 300);
      endcase
      rand_msg(len);
      run_msg($sformatf("rnd%0d_len%0d", t, len), 1'($urandom),
              $urandom_range(40, 100), $urandom_range(30, 100), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
